imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
- Writer side of the 32-bit instruction memory: receives a framed byte stream from a host link (UART/JTAG bridge) and writes program words into the memory's write port, starting at word 0.
- Holds the CPU fetch path in hold until a complete frame with a valid checksum has been written.
- Sits between the host byte interface and the instruction memory write port, alongside the existing synchronous-read fetch port.

Parameters:
- DEPTH, 64, number of 32-bit words in instruction memory (max 255).
- ADDR_W, 6, width of the word address (log2 DEPTH).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  one-cycle pulse; returns the loader from DONE/ERR to IDLE.
- in_data  input  8  host byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts the byte this cycle.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_waddr  output  ADDR_W  word address for the write.
- mem_wdata  output  32  instruction word for the write.
- cpu_hold  output  1  1 = CPU held, PC frozen at 0.
- done  output  1  frame loaded and checksum matched.
- error  output  1  frame rejected.
- words_loaded  output  ADDR_W+1  count of words written in the current frame.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Port names are clk and rst_n.
- Reset values: state=IDLE, in_ready=1, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0. Byte counter, word count and checksum are cleared.
- A byte is accepted on a rising edge with in_valid && in_ready. in_ready=1 in IDLE, COUNT, DATA and CHECK, and 0 in DONE and ERR.
- Frame format: header 0xA5, count byte N (words), N×4 payload bytes (big-endian, first byte = bits 31:24), checksum byte. The checksum is the XOR of all payload bytes only.
- State IDLE: accepted byte 0xA5 -> COUNT. Any other accepted byte is discarded and the state stays IDLE.
- State COUNT: N=0 or N>DEPTH -> ERR. Otherwise latch N, clear checksum, word index and byte index -> DATA.
- State DATA:
  - Each accepted byte is shifted into the word register and XORed into the checksum.
  - On the 4th byte of a word, the next cycle presents mem_we=1, mem_waddr=word index and mem_wdata=the assembled word for exactly one cycle, and words_loaded increments in that same cycle.
  - After the write of word N-1 -> CHECK.
  - Latency from acceptance of the last byte of a word to mem_we is 1 cycle.
- State CHECK: the accepted byte is compared to the checksum. Equal -> DONE, else -> ERR, with the new state taking effect the cycle after acceptance.
- State DONE: done=1, cpu_hold=0.
- State ERR: error=1, cpu_hold stays 1.
- Leaving DONE/ERR: start=1 -> IDLE, which sets cpu_hold=1, clears done, error and words_loaded, and puts in_ready=1 the next cycle. start is ignored in the other states.
- Words already written are never rolled back on error. The CPU stays held, so it cannot fetch them.
- Simultaneous start and rst_n=0: reset wins.
- Reset mid-frame: the partial word is discarded, no mem_we is issued, and the loader returns to IDLE. Memory contents already written are untouched.
- in_valid gaps: any number of idle cycles between bytes is legal and state is held. There is no timeout.
- mem_waddr wraps never: N≤DEPTH guarantees the address stays ≤ DEPTH-1.

Test Plan:
- Good frame: bytes A5 02 12 34 56 78 DE AD BE EF 2A -> mem_we pulses at addr 0 with data 0x12345678, then at addr 1 with data 0xDEADBEEF, each 1 cycle after the 4th byte. The cycle after 0x2A: done=1, cpu_hold=0, words_loaded=2.
- Noise then frame: bytes 00 FF 5A, then the good frame -> the 3 noise bytes are accepted and dropped with no mem_we. The result is identical to the good-frame scenario.
- Bad checksum: same frame with last byte 0x2B -> both writes occur; then error=1, done=0, cpu_hold=1, in_ready=0. A start pulse -> IDLE, error=0, in_ready=1.
- Bad count: A5 00 -> ERR with no writes. After start, A5 41 (65>64) -> ERR with no writes.
- Reset mid-word: A5 01 12 34, then rst_n=0 for 1 cycle -> no mem_we, all outputs at reset values. A following frame A5 01 AA BB CC DD 00 -> write addr 0 = 0xAABBCCDD, done=1 (checksum AA^BB^CC^DD=0x00).
- Gapped stream: good frame with 3 idle cycles (in_valid=0) between every byte -> same writes and result as the good-frame scenario, with each mem_we still exactly 1 cycle wide.

Source files
------------

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader: framed host bytes to memory writes.
// Frame: A5, N, N*4 big-endian payload bytes, XOR checksum of the payload.
module imem_program_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W:0] WL_ONE  = (ADDR_W+1)'(1);
    localparam logic [7:0]      DEPTH_B = 8'(DEPTH);

    state_t            state_q, state_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [23:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              rdy_q, rdy_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept;

    assign accept       = in_valid && rdy_q;
    assign in_ready     = rdy_q;
    assign mem_we       = we_q;
    assign mem_waddr    = waddr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign error        = err_q;
    assign words_loaded = cnt_q;

    // Next-state and registered-output computation for the frame parser.
    always_comb begin
        state_d = state_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        csum_d  = csum_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        rdy_d   = rdy_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && in_data == 8'hA5) begin
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (accept) begin
                    if (in_data == 8'd0 || in_data > DEPTH_B) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        rdy_d   = 1'b0;
                    end else begin
                        n_d     = (ADDR_W+1)'(in_data);
                        csum_d  = 8'd0;
                        cnt_d   = '0;
                        bidx_d  = 2'd0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d = {word_q[15:0], in_data};
                    csum_d = csum_q ^ in_data;
                    bidx_d = 2'(bidx_q + 2'd1);
                    if (bidx_q == 2'd3) begin
                        // The word is complete: write it next cycle.
                        we_d    = 1'b1;
                        waddr_d = cnt_q[ADDR_W-1:0];
                        wdata_d = {word_q, in_data};
                        cnt_d   = cnt_q + WL_ONE;
                        if (cnt_q + WL_ONE == n_q) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    rdy_d = 1'b0;
                    if (in_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_IDLE;
                    rdy_d   = 1'b1;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bidx_q  <= 2'd0;
            word_q  <= 24'd0;
            csum_q  <= 8'd0;
            n_q     <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b1;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 32'd0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bidx_q  <= bidx_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: frame-level reference model plus
// directed frames and randomized frames with gaps, noise and resets.
module tb_imem_program_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    localparam int P_IDLE  = 0;
    localparam int P_COUNT = 1;
    localparam int P_DATA  = 2;
    localparam int P_CHECK = 3;
    localparam int P_DONE  = 4;
    localparam int P_ERR   = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    imem_program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the frame at byte level.
    int          ph = P_IDLE;
    int          n = 0;
    int          nb = 0;
    int          k = 0;
    int          e_wl = 0;
    logic [7:0]  pay [0:4*DEPTH-1];
    logic [7:0]  cs;
    logic        e_rdy = 1'b1;
    logic        e_we = 1'b0;
    logic        e_hold = 1'b1;
    logic        e_done = 1'b0;
    logic        e_err = 1'b0;
    logic [31:0] e_wdata = 32'd0;
    int          e_waddr = 0;
    bit          live = 1'b0;

    always @(posedge clk) begin
        live = 1'b1;
        if (!rst_n) begin
            ph = P_IDLE; nb = 0; e_wl = 0;
            e_rdy = 1'b1; e_we = 1'b0; e_hold = 1'b1;
            e_done = 1'b0; e_err = 1'b0; e_wdata = 32'd0; e_waddr = 0;
        end else begin
            e_we = 1'b0;
            if (ph == P_DONE || ph == P_ERR) begin
                if (start) begin
                    ph = P_IDLE; e_rdy = 1'b1; e_hold = 1'b1;
                    e_done = 1'b0; e_err = 1'b0; e_wl = 0;
                end
            end else if (in_valid && e_rdy) begin
                case (ph)
                    P_IDLE: if (in_data == 8'hA5) ph = P_COUNT;
                    P_COUNT: begin
                        n = int'(in_data);
                        if (n == 0 || n > DEPTH) begin
                            ph = P_ERR; e_err = 1'b1; e_rdy = 1'b0;
                        end else begin
                            nb = 0; ph = P_DATA;
                        end
                    end
                    P_DATA: begin
                        pay[nb] = in_data;
                        nb++;
                        if (nb % 4 == 0) begin
                            k = nb / 4 - 1;
                            e_we = 1'b1;
                            e_waddr = k;
                            e_wdata = {pay[4*k], pay[4*k+1],
                                       pay[4*k+2], pay[4*k+3]};
                            e_wl = k + 1;
                            if (k + 1 == n) ph = P_CHECK;
                        end
                    end
                    P_CHECK: begin
                        cs = 8'd0;
                        for (int i = 0; i < 4 * n; i++) cs ^= pay[i];
                        e_rdy = 1'b0;
                        if (in_data == cs) begin
                            ph = P_DONE; e_done = 1'b1; e_hold = 1'b0;
                        end else begin
                            ph = P_ERR; e_err = 1'b1;
                        end
                    end
                    default: ph = P_IDLE;
                endcase
            end
        end
    end

    // Memory image and write counter observed from the write port.
    logic [31:0] mem_img [0:DEPTH-1];
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            mem_img[mem_waddr] = mem_wdata;
            wr_cnt++;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (live) begin
            chk("in_ready", 32'(in_ready), 32'(e_rdy));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            if (e_we) begin
                chk("mem_waddr", 32'(mem_waddr), 32'(e_waddr));
                chk("mem_wdata", mem_wdata, e_wdata);
            end
            chk("cpu_hold", 32'(cpu_hold), 32'(e_hold));
            chk("done", 32'(done), 32'(e_done));
            chk("error", 32'(error), 32'(e_err));
            chk("words_loaded", 32'(words_loaded), 32'(e_wl));
        end
    end

    bit rnd_start = 1'b0;

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            start = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data = b;
        start = rnd_start && ($urandom_range(0, 7) == 0);
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) begin
            @(negedge clk);
            in_valid = 1'b0;
            start = 1'b0;
        end
    endtask

    task automatic send_q(input logic [7:0] q[$], input int gap);
        foreach (q[i]) send(q[i], gap);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'($urandom_range(0, 1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
    endtask

    task automatic good_frame_checks(input string tag, input int w0);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_wl"}, 32'(words_loaded), 32'd2);
        chk({tag, "_m0"}, mem_img[0], 32'h12345678);
        chk({tag, "_m1"}, mem_img[1], 32'hDEADBEEF);
        chk({tag, "_nwr"}, 32'(wr_cnt - w0), 32'd2);
    endtask

    logic [7:0] good[$];
    logic [7:0] q[$];
    int         w0;

    initial begin
        good = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2A};
        idle(2);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_wl", 32'(words_loaded), 32'd0);
        rst_n = 1'b1;

        w0 = wr_cnt;
        send_q(good, 0);
        idle(1);
        good_frame_checks("good", w0);
        pulse_start();
        chk("start_hold", 32'(cpu_hold), 32'd1);
        chk("start_wl", 32'(words_loaded), 32'd0);

        w0 = wr_cnt;
        q = '{8'h00, 8'hFF, 8'h5A};
        send_q(q, 0);
        send_q(good, 0);
        idle(1);
        good_frame_checks("noise", w0);
        pulse_start();

        w0 = wr_cnt;
        q = good;
        q[10] = 8'h2B;
        send_q(q, 0);
        idle(1);
        chk("badcs_err", 32'(error), 32'd1);
        chk("badcs_done", 32'(done), 32'd0);
        chk("badcs_hold", 32'(cpu_hold), 32'd1);
        chk("badcs_rdy", 32'(in_ready), 32'd0);
        chk("badcs_nwr", 32'(wr_cnt - w0), 32'd2);
        pulse_start();
        chk("badcs_clr", 32'(error), 32'd0);
        chk("badcs_rdy2", 32'(in_ready), 32'd1);

        w0 = wr_cnt;
        q = '{8'hA5, 8'h00};
        send_q(q, 0);
        idle(1);
        chk("cnt0_err", 32'(error), 32'd1);
        pulse_start();
        q = '{8'hA5, 8'h41};
        send_q(q, 0);
        idle(1);
        chk("cnt65_err", 32'(error), 32'd1);
        chk("badcnt_nwr", 32'(wr_cnt - w0), 32'd0);
        pulse_start();

        w0 = wr_cnt;
        q = '{8'hA5, 8'h01, 8'h12, 8'h34};
        send_q(q, 0);
        do_reset();
        chk("rstmid_nwr", 32'(wr_cnt - w0), 32'd0);
        chk("rstmid_rdy", 32'(in_ready), 32'd1);
        q = '{8'hA5, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        send_q(q, 0);
        idle(1);
        chk("rstmid_done", 32'(done), 32'd1);
        chk("rstmid_m0", mem_img[0], 32'hAABBCCDD);
        pulse_start();

        w0 = wr_cnt;
        send_q(good, 3);
        idle(1);
        good_frame_checks("gap", w0);
        pulse_start();

        q = '{8'hA5, 8'(DEPTH)};
        cs = 8'd0;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            q.push_back(8'($urandom));
            cs ^= q[q.size()-1];
        end
        q.push_back(cs);
        send_q(q, 0);
        idle(1);
        chk("full_done", 32'(done), 32'd1);
        chk("full_wl", 32'(words_loaded), 32'(DEPTH));
        chk("full_last", mem_img[DEPTH-1],
            {q[4*DEPTH-2], q[4*DEPTH-1], q[4*DEPTH], q[4*DEPTH+1]});
        pulse_start();

        rnd_start = 1'b1;
        for (int it = 0; it < 40; it++) begin
            int nw;
            int gap;
            int abort;
            logic [7:0] b;
            q = {};
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    b = 8'($urandom);
                    if (b == 8'hA5) b = 8'h00;
                    q.push_back(b);
                end
            end
            q.push_back(8'hA5);
            nw = $urandom_range(1, 8);
            case ($urandom_range(0, 9))
                0: q.push_back(8'h00);
                1: q.push_back(8'($urandom_range(DEPTH + 1, 255)));
                default: q.push_back(8'(nw));
            endcase
            cs = 8'd0;
            for (int i = 0; i < 4 * nw; i++) begin
                b = 8'($urandom);
                cs ^= b;
                q.push_back(b);
            end
            if ($urandom_range(0, 3) == 0) cs ^= 8'(($urandom_range(1, 255)));
            q.push_back(cs);
            gap = $urandom_range(0, 2);
            abort = ($urandom_range(0, 5) == 0) ?
                    int'($urandom_range(0, q.size() - 1)) : -1;
            foreach (q[i]) begin
                if (i == abort) break;
                send(q[i], gap);
            end
            if (abort >= 0) do_reset();
            idle(2);
            if (ph == P_DONE || ph == P_ERR) pulse_start();
            else if (ph != P_IDLE) do_reset();
        end
        rnd_start = 1'b0;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
